// File: rtl/file_writer_pkg.sv
// Shared image geometry and capture FSM encoding for the file streamer/writer pair.
package file_writer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } fw_state_e;

endpackage

// File: rtl/file_writer_image_ram.sv
// Simple dual-port image memory: one synchronous write port, one registered read port.
module image_ram
    import file_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Contents survive reset; a same-address read returns the pre-write word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/file_writer.sv
// Captures a valid/ready byte stream line by line into an image memory with read-back.
module file_writer
    import file_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  data_last,
    output logic                  data_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   line_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH:0] LAST_LINE = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

    fw_state_e           state_d, state_q;
    logic [ADDR_WIDTH:0] line_count_d, line_count_q;
    logic                overflow_d, overflow_q;
    logic                wr_en;

    always_comb begin
        state_d      = state_q;
        line_count_d = line_count_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start takes priority: same-edge data is dropped without flagging
                if (start) begin
                    state_d      = ST_CAPTURE;
                    line_count_d = '0;
                    overflow_d   = 1'b0;
                end else if (data_valid) begin
                    overflow_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (data_valid) begin
                    wr_en        = 1'b1;
                    line_count_d = line_count_q + ONE;
                    if (data_last || (line_count_q == LAST_LINE)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            line_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_count_q <= line_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data_ready = (state_q == ST_CAPTURE);
    assign busy       = (state_q == ST_CAPTURE);
    assign done       = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign line_count = line_count_q;

    image_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_image_ram (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(line_count_q[ADDR_WIDTH-1:0]),
        .wr_data(data_in),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_file_writer.sv
// Self-checking bench for file_writer: flag checks plus a read-back scoreboard.
module tb_file_writer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_last = 1'b0;
    logic       data_ready;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [7:0] line_count;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [128];
    logic [7:0] rd_q [$];

    file_writer #(
        .DATA_WIDTH(8),
        .DEPTH     (128),
        .ADDR_WIDTH(7)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_last (data_last),
        .data_ready(data_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .line_count(line_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic put(input logic [7:0] d, input logic last);
        data_in    = d;
        data_last  = last;
        data_valid = 1'b1;
        mdl[line_count[6:0]] = d;
        tick();
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        logic [7:0] exp;
        rd_addr = a;
        rd_q.push_back(mdl[a]);
        tick();
        if (rd_q.size() == 0) begin
            check("rd_queue_empty", 32'd1, 32'd0);
        end else begin
            exp = rd_q.pop_front();
            check($sformatf("rd[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
        end
    endtask

    task automatic check_idle_flags(input string tag);
        check({tag, "_ready"}, {31'd0, data_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        check({tag, "_done"},  {31'd0, done},       32'd0);
        check({tag, "_ovf"},   {31'd0, overflow},   32'd0);
        check({tag, "_count"}, {24'd0, line_count}, 32'd0);
    endtask

    initial begin
        logic [7:0] tbl [4];
        tbl[0] = 8'hA1; tbl[1] = 8'hB2; tbl[2] = 8'hC3; tbl[3] = 8'hD4;

        tick();
        tick();
        check_idle_flags("reset");
        check("reset_rd", {24'd0, rd_data}, 32'd0);
        reset = 1'b0;
        tick();

        // stray data before any start
        data_valid = 1'b1;
        tick();
        check("idle_ovf",   {31'd0, overflow},   32'd1);
        check("idle_ready", {31'd0, data_ready}, 32'd0);
        check("idle_count", {24'd0, line_count}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        data_valid = 1'b0;
        check("start_wins_ovf",  {31'd0, overflow},   32'd0);
        check("start_wins_busy", {31'd0, busy},       32'd1);
        check("start_wins_cnt",  {24'd0, line_count}, 32'd0);

        // four-line capture ending on data_last
        for (int i = 0; i < 4; i++) put(tbl[i], i == 3);
        check("t1_done",  {31'd0, done},       32'd1);
        check("t1_count", {24'd0, line_count}, 32'd4);
        check("t1_ready", {31'd0, data_ready}, 32'd0);
        for (int i = 0; i < 4; i++) rd(7'(i));

        // full image, no data_last
        pulse_start();
        check("t2_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 128; i++) begin
            if (i == 127) check("t2_not_done_early", {31'd0, done}, 32'd0);
            put(8'(i), 1'b0);
        end
        check("t2_done",  {31'd0, done},       32'd1);
        check("t2_count", {24'd0, line_count}, 32'd128);
        rd(7'd127);
        data_in    = 8'hEE;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("t2_ovf", {31'd0, overflow}, 32'd1);
        rd(7'd0);

        // restart from DONE with overflow set
        pulse_start();
        check("t5_ovf",   {31'd0, overflow},   32'd0);
        check("t5_done",  {31'd0, done},       32'd0);
        check("t5_count", {24'd0, line_count}, 32'd0);
        check("t5_busy",  {31'd0, busy},       32'd1);
        put(8'h55, 1'b0);
        put(8'h66, 1'b1);
        check("t5_count2", {24'd0, line_count}, 32'd2);
        for (int i = 0; i < 3; i++) rd(7'(i));

        // gapped valid: only handshake cycles write
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0) begin
                put(8'(8'h90 + c), c == 4);
            end else begin
                tick();
            end
        end
        check("t3_count", {24'd0, line_count}, 32'd3);
        check("t3_ovf",   {31'd0, overflow},   32'd0);
        check("t3_done",  {31'd0, done},       32'd1);
        for (int i = 0; i < 4; i++) rd(7'(i));

        // reset in the middle of a 20-line capture
        pulse_start();
        for (int i = 0; i < 10; i++) put(8'(8'h30 + i), 1'b0);
        check("t4_mid_count", {24'd0, line_count}, 32'd10);
        reset = 1'b1;
        #1;
        check_idle_flags("async_rst");
        tick();
        check_idle_flags("rst_next");
        check("rst_rd", {24'd0, rd_data}, 32'd0);
        reset = 1'b0;
        tick();
        rd(7'd5);
        rd(7'd9);

        if (rd_q.size() != 0) check("rd_queue_left", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/file_writer.md
Name: file_writer

Overview:
- Write-side counterpart of the program/data file streamer.
- Accepts a byte stream over a valid/ready handshake and stores it line by line into a DEPTH x DATA_WIDTH image memory, starting at line 0.
- Reports the number of lines captured and a done flag.
- Exposes a registered read port so the processor or the bench can read the captured image back.

Parameters:
- DATA_WIDTH, 8, width of one line/word.
- DEPTH, 128, number of lines in the image memory.
- ADDR_WIDTH, 7, line address width; must equal clog2(DEPTH).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new capture at line 0.
- data_in  in  DATA_WIDTH  incoming line.
- data_valid  in  1  data_in is valid this cycle.
- data_last  in  1  qualifies data_in as the final line; meaningful only with data_valid.
- data_ready  out  1  block accepts data this cycle.
- busy  out  1  capture in progress.
- done  out  1  capture finished; stays high until the next start or reset.
- overflow  out  1  sticky; data_valid was seen while not accepting.
- line_count  out  ADDR_WIDTH+1  number of lines written in the current or last capture (0..DEPTH).
- rd_addr  in  ADDR_WIDTH  read-back line address.
- rd_data  out  DATA_WIDTH  read-back data, 1-cycle latency.

Behaviour:
- Reset state: IDLE; data_ready=0, busy=0, done=0, overflow=0, line_count=0, rd_data=0. Memory contents are not cleared.
- FSM states and transitions:
  - IDLE --start--> CAPTURE.
  - CAPTURE --end condition--> DONE.
  - DONE --start--> CAPTURE.
  - No other transitions.
- Entering CAPTURE (from IDLE or DONE): line_count<=0, done<=0, overflow<=0 on the start edge. The first handshake is possible the following cycle.
- In CAPTURE:
  - data_ready=1 and busy=1, both decoded from state (Moore).
  - Transfer occurs when data_valid && data_ready at a clock edge.
  - On transfer: mem[line_count[ADDR_WIDTH-1:0]] <= data_in; line_count <= line_count+1.
- End of capture: the transfer carries data_last=1, or the transfer writes line DEPTH-1. Next state is DONE and done rises the cycle after that transfer.
- Full image: line_count reads DEPTH (128) in DONE; the counter never wraps.
- data_last on the first transfer gives line_count=1, done.
- start while in CAPTURE is ignored; the capture continues.
- overflow sets when data_valid=1 in IDLE or DONE. The offending data is dropped and memory is unchanged. overflow stays set until start or reset.
- Same-edge start and data_valid in IDLE/DONE: start wins; the data is dropped and overflow is not set.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in any state.
  - Read-during-write to the same address returns the old contents.
- Reset mid-capture: return to IDLE immediately; line_count=0, done=0. Lines already written remain in memory.
- data_last without data_valid is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2.
  - DEFAULT_DATA_WIDTH=8 and DEFAULT_DEPTH=128, also used by the file streamer so both agree on image geometry.
- One natural sub-module: image_ram. It is a simple dual-port RAM with one synchronous write port and one registered read port, DEPTH x DATA_WIDTH, and holds the memory array.
- FSM, counter and flags stay in file_writer.

Test Plan:
- Reset, then start, then 4 transfers 8'hA1, 8'hB2, 8'hC3, 8'hD4, the last with data_last=1 -> done=1 one cycle after the 4th transfer; line_count=4; data_ready=0. rd_addr=0..3 returns A1, B2, C3, D4, each 1 cycle after its address.
- Start, then 128 back-to-back transfers of data=index with data_last never set -> done after the 128th; line_count=128. rd_addr=127 returns 8'h7F. A 129th data_valid sets overflow=1; mem[0] still 8'h00.
- Start, 3 transfers with data_valid toggled every other cycle -> only the handshake cycles write; line_count=3; no overflow.
- Assert reset after 10 transfers of a 20-line capture -> all outputs at reset values next cycle; rd_addr=5 still returns the 6th written value.
- In DONE with overflow=1, pulse start -> overflow=0, done=0, line_count=0, busy=1. A new 2-line capture overwrites lines 0..1 only; line 2 keeps its old value.
- data_valid in IDLE before any start -> overflow=1, data_ready=0, line_count=0. Then start with data_valid high on the same edge -> overflow=0 next cycle.
